// File: rtl/pagerank_gather_accumulator.sv
// Multi-lane PageRank gather accumulator: merges same-cycle lane updates to one
// destination, then accumulates into the rank array through a 2-stage pipeline.
module pagerank_gather_accumulator #(
    parameter int unsigned NODES_IN_GRAPH = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NUM_LANES      = 2,
    parameter int unsigned ID_WIDTH       = 32,
    parameter bit          SATURATE       = 1'b1
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic                                          pagerank_enable,
    input  logic                                          nextIteration,
    input  logic [NUM_LANES-1:0]                          lane_valid,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]          lane_data,
    input  logic [NUM_LANES-1:0][ID_WIDTH-1:0]            lane_dest_id,
    input  logic                                          scatter_operation_complete,
    output logic [NODES_IN_GRAPH-1:0][DATA_WIDTH-1:0]     pagerank_pre_damp,
    output logic                                          gather_operation_complete,
    output logic [31:0]                                   update_count,
    output logic                                          id_error,
    output logic                                          overflow_error
);

    localparam int unsigned NODE_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
    localparam int unsigned SUM_W  = DATA_WIDTH + 1;
    localparam int unsigned CMP_W  = (ID_WIDTH > 32) ? ID_WIDTH : 32;

    // Returns {carry, result}; result is clamped to all-ones on carry when saturating.
    function automatic logic [SUM_W-1:0] rule_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        logic [SUM_W-1:0] raw;
        raw = SUM_W'(a) + SUM_W'(b);
        if (SATURATE && raw[DATA_WIDTH]) begin
            raw = {1'b1, {DATA_WIDTH{1'b1}}};
        end
        return raw;
    endfunction

    logic [NUM_LANES-1:0]                      s1_valid_d, s1_valid_q;
    logic [NUM_LANES-1:0][NODE_W-1:0]          s1_id_d, s1_id_q;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      s1_sum_d, s1_sum_q;
    logic [NODES_IN_GRAPH-1:0][DATA_WIDTH-1:0] rank_d, rank_q;
    logic [31:0]                               update_count_d, update_count_q;
    logic                                      id_error_d, id_error_q;
    logic                                      overflow_d, overflow_q;
    logic                                      complete_d, complete_q;
    logic                                      gather_d, gather_q;

    logic [NUM_LANES-1:0] lane_active_c;
    logic                 id_bad_c;
    logic                 merge_ovf_c;
    logic [31:0]          accept_cnt_c;
    logic                 head_c;
    logic [DATA_WIDTH-1:0] merge_acc_c;
    logic [SUM_W-1:0]     merge_r_c;
    logic                 apply_ovf_c;
    logic [SUM_W-1:0]     apply_r_c;

    // S0: qualify lanes, then fold every duplicate destination into its lowest-index lane.
    always_comb begin
        lane_active_c = '0;
        id_bad_c      = 1'b0;
        merge_ovf_c   = 1'b0;
        accept_cnt_c  = '0;
        head_c        = 1'b0;
        merge_acc_c   = '0;
        merge_r_c     = '0;
        s1_valid_d    = '0;
        s1_id_d       = '0;
        s1_sum_d      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_active_c[i] = lane_valid[i] &&
                               (CMP_W'(lane_dest_id[i]) < CMP_W'(NODES_IN_GRAPH));
            id_bad_c         = id_bad_c | (lane_valid[i] & ~lane_active_c[i]);
            accept_cnt_c     = accept_cnt_c + 32'(lane_active_c[i]);
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            head_c = lane_active_c[i];
            for (int j = 0; j < i; j++) begin
                if (lane_active_c[j] && (lane_dest_id[j] == lane_dest_id[i])) begin
                    head_c = 1'b0;
                end
            end
            merge_acc_c = lane_data[i];
            for (int k = i + 1; k < NUM_LANES; k++) begin
                if (head_c && lane_active_c[k] && (lane_dest_id[k] == lane_dest_id[i])) begin
                    merge_r_c   = rule_add(merge_acc_c, lane_data[k]);
                    merge_acc_c = merge_r_c[DATA_WIDTH-1:0];
                    merge_ovf_c = merge_ovf_c | merge_r_c[DATA_WIDTH];
                end
            end
            s1_valid_d[i] = head_c;
            s1_id_d[i]    = head_c ? NODE_W'(lane_dest_id[i]) : '0;
            s1_sum_d[i]   = head_c ? merge_acc_c : '0;
        end
    end

    // S2: read-modify-write of the rank array; S1 ids are unique so lanes never collide.
    always_comb begin
        rank_d      = rank_q;
        apply_ovf_c = 1'b0;
        apply_r_c   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (s1_valid_q[l]) begin
                apply_r_c              = rule_add(rank_q[s1_id_q[l]], s1_sum_q[l]);
                rank_d[s1_id_q[l]]     = apply_r_c[DATA_WIDTH-1:0];
                apply_ovf_c            = apply_ovf_c | apply_r_c[DATA_WIDTH];
            end
        end
    end

    // Completion waits for S1 to be empty so the final batch has reached the array.
    always_comb begin
        update_count_d = update_count_q + accept_cnt_c;
        id_error_d     = id_error_q | id_bad_c;
        overflow_d     = overflow_q | merge_ovf_c | apply_ovf_c;
        complete_d     = complete_q | scatter_operation_complete;
        gather_d       = gather_q | (complete_q & ~(|s1_valid_q));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q     <= '0;
            s1_id_q        <= '0;
            s1_sum_q       <= '0;
            rank_q         <= '0;
            update_count_q <= '0;
            id_error_q     <= 1'b0;
            overflow_q     <= 1'b0;
            complete_q     <= 1'b0;
            gather_q       <= 1'b0;
        end else if (nextIteration) begin
            s1_valid_q     <= '0;
            s1_id_q        <= '0;
            s1_sum_q       <= '0;
            rank_q         <= '0;
            update_count_q <= '0;
            id_error_q     <= 1'b0;
            overflow_q     <= 1'b0;
            complete_q     <= 1'b0;
            gather_q       <= 1'b0;
        end else if (pagerank_enable) begin
            s1_valid_q     <= s1_valid_d;
            s1_id_q        <= s1_id_d;
            s1_sum_q       <= s1_sum_d;
            rank_q         <= rank_d;
            update_count_q <= update_count_d;
            id_error_q     <= id_error_d;
            overflow_q     <= overflow_d;
            complete_q     <= complete_d;
            gather_q       <= gather_d;
        end
    end

    assign pagerank_pre_damp         = rank_q;
    assign gather_operation_complete = gather_q;
    assign update_count              = update_count_q;
    assign id_error                  = id_error_q;
    assign overflow_error            = overflow_q;

endmodule

// File: doc/pagerank_gather_accumulator.md
Name: pagerank_gather_accumulator

Overview:
- Multi-lane successor to the per-partition gather accumulator.
- Accepts NUM_LANES scatter updates per cycle and merges lanes that target the same destination in the same cycle.
- Accumulates into NODES_IN_GRAPH rank registers through a 2-stage pipeline, with selectable saturating or wrapping arithmetic.
- Sits between the scatter phase and the damping/apply stage. Signals gather completion only after the pipeline has drained.

Parameters:
- NODES_IN_GRAPH, 32, number of rank registers (destination nodes).
- DATA_WIDTH, 64, width of page-rank values and accumulators (unsigned).
- NUM_LANES, 2, parallel scatter update lanes (1..8).
- ID_WIDTH, 32, width of each destination id.
- SATURATE, 1, 1 = clamp sums at all-ones; 0 = wrap modulo 2^DATA_WIDTH.

Ports:
- clock  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pagerank_enable  input  1  global advance/accept enable; low freezes the whole block.
- nextIteration  input  1  synchronous clear for a new iteration.
- lane_valid  input  [NUM_LANES]  per-lane update valid.
- lane_data  input  [NUM_LANES][DATA_WIDTH]  per-lane scatter rank contribution.
- lane_dest_id  input  [NUM_LANES][ID_WIDTH]  per-lane destination node id.
- scatter_operation_complete  input  1  scatter phase has issued its last update.
- pagerank_pre_damp  output  [NODES_IN_GRAPH][DATA_WIDTH]  accumulated pre-damping ranks (register outputs).
- gather_operation_complete  output  1  all updates applied; sticky until clear.
- update_count  output  32  number of accepted valid, in-range lane updates this iteration.
- id_error  output  1  sticky; set when a valid lane carries dest_id >= NODES_IN_GRAPH.
- overflow_error  output  1  sticky; set on any accumulate overflow (also set when SATURATE=1 clamps).

Behaviour:
- Reset (async, reset_n low): all rank registers, S1 stage, update_count, id_error, overflow_error, gather_operation_complete and the complete latch go to 0.
- nextIteration (sync): same clear as reset. It has priority over enable and all inputs; lane updates and complete in that cycle are dropped.
- pagerank_enable low: no state changes at all. Inputs are ignored, S1 holds, the array holds, flags hold.
- S0 (combinational, enable high):
  - A lane is active when lane_valid=1 and dest_id < NODES_IN_GRAPH.
  - A valid lane with an out-of-range id is dropped and sets id_error.
  - Active lanes with equal dest_id are merged into the lowest-index such lane. The merged sum uses the same saturate/wrap rule; overflow during the merge sets overflow_error.
  - Each remaining lane carries (valid, id, sum).
- S1 register: captures the merged lane vector on each enabled edge. update_count increments by the number of active lanes (pre-merge) in that cycle.
- S2 (array update):
  - Each valid S1 lane does reg[id] <= reg[id] + sum.
  - Ids are unique within S1 by construction, so there is no intra-cycle write conflict.
  - Read-modify-write uses the current register value, so back-to-back updates to the same id accumulate correctly with no forwarding.
- Latency: a lane presented at edge t is visible on pagerank_pre_damp after edge t+1, i.e. 2 enabled edges including capture.
- Arithmetic: unsigned, DATA_WIDTH bits.
  - SATURATE=1: result = all-ones if the true sum >= 2^DATA_WIDTH.
  - SATURATE=0: low DATA_WIDTH bits.
  - Either mode sets overflow_error on a carry-out.
- Completion:
  - scatter_operation_complete=1 on an enabled edge sets an internal complete latch. Updates presented in that same cycle are still accepted.
  - gather_operation_complete rises on the first enabled edge where the latch is set and S1 holds no valid lanes after that edge's update. Nominal: complete at t gives the output high after t+2.
  - Once high, it stays high until reset or nextIteration. Updates arriving after completion are still applied and counted, and do not drop the flag.
- Counter update_count wraps at 2^32.

Test Plan:
- Single lane, id 5, data 10 then 7 on consecutive cycles -> reg[5]=10 after 2nd edge, 17 after 3rd; other regs 0; update_count=2.
- Lane0 and lane1 both id 3, data 4 and 6, same cycle -> reg[3]=10 after 2 edges; update_count=2; reg[3] never shows a partial 4 or 6.
- SATURATE=1, reg[0]=2^64-2, add 5 -> reg[0]=all-ones, overflow_error=1. With SATURATE=0 -> reg[0]=3, overflow_error=1.
- Lane1 id 40 with NODES_IN_GRAPH=32 -> dropped, id_error=1, update_count unchanged, array unchanged.
- Last update and scatter_operation_complete in the same cycle t -> gather_operation_complete low after t+1, high after t+2, update included. Toggling pagerank_enable low for 3 cycles mid-pipeline delays everything by exactly 3 cycles.
- nextIteration asserted together with a valid update and complete -> all regs, count, flags and complete are 0 next cycle and the update is discarded. reset_n pulsed asynchronously mid-accumulation -> immediate zeroing.
